async_fifo_drain: RTL

//  Read-side controller for async_fifo, running entirely in the r_clk domain.
//  - Watches the FIFO status flags, issues r_en and captures d_out.
//  - Presents captured words downstream on a valid/ready stream through a 2-entry skid buffer.
//  - Optional burst mode holds off draining until the FIFO is half full or a timeout expires.

---
 rtl/async_fifo_drain.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/async_fifo_drain.sv
// -----------------------------------------------------------------------------
// async_fifo_drain
//   Read-side controller for async_fifo, running entirely in the r_clk domain.
//   It watches the FIFO status flags, issues r_en and captures fifo_d_out one
//   cycle after each read. Captured words go downstream through a 2-entry skid
//   buffer. In burst mode, draining waits until the FIFO is half full or until
//   a timeout expires.
//
// Ports
//   r_clk               in   read-domain clock
//   reset               in   synchronous, active-high reset
//   f_empty_flag        in   FIFO empty
//   f_almost_empty_flag in   FIFO holds <= 1 word
//   f_half_full_flag    in   FIFO at least half full
//   fifo_d_out          in   FIFO read data, valid the cycle after r_en
//   burst_mode          in   1: batch draining, 0: drain whenever not empty
//   m_ready             in   downstream accepts m_data
//   r_en                out  FIFO read strobe
//   m_data              out  head of skid buffer
//   m_valid             out  m_data holds a word
//   rd_count            out  accepted downstream beats (wraps)
//   timeout_evt         out  1-cycle pulse when the burst timeout forces a drain
//   dbg_state           out  FSM state (0 = IDLE, 1 = DRAIN)
//
// Handshake: a beat transfers on every r_clk edge where m_valid && m_ready.
// m_valid never depends on m_ready, and m_data is held while m_valid && !m_ready.
// -----------------------------------------------------------------------------
module async_fifo_drain #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              r_clk,
    input  logic              reset,
    input  logic              f_empty_flag,
    input  logic              f_almost_empty_flag,
    input  logic              f_half_full_flag,
    input  logic [DATA_W-1:0] fifo_d_out,
    input  logic              burst_mode,
    input  logic              m_ready,
    output logic              r_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic [CNT_W-1:0]  rd_count,
    output logic              timeout_evt,
    output logic              dbg_state
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [TMR_W-1:0]  timer, timer_next;
    logic              in_flight;      // r_en was high last cycle: capture now
    logic [DATA_W-1:0] buf0, buf1;     // buf0 is always the head
    logic [1:0]        occ;
    logic              push, pop;

    assign push      = in_flight;
    assign pop       = m_valid && m_ready;
    assign m_valid   = (occ != 2'd0);
    assign m_data    = buf0;
    assign dbg_state = (state == DRAIN);

    always_comb begin
        state_next  = state;
        timer_next  = timer;
        timeout_evt = 1'b0;
        r_en        = 1'b0;
        case (state)
            IDLE: begin
                if (!burst_mode) begin
                    timer_next = '0;
                    if (!f_empty_flag) state_next = DRAIN;
                end else if (f_half_full_flag) begin
                    timer_next = '0;
                    state_next = DRAIN;
                end else if (f_empty_flag) begin
                    timer_next = '0;
                end else if (timer == TMR_LAST) begin
                    timer_next  = '0;
                    state_next  = DRAIN;
                    timeout_evt = 1'b1;
                end else begin
                    timer_next = timer + TMR_W'(1);
                end
            end
            DRAIN: begin
                timer_next = '0;
                // Credit: every read already in flight must have a free slot
                // waiting for it; at <=1 word, never read on consecutive cycles
                // because the flag may still reflect the previous read.
                r_en = !f_empty_flag
                       && (({1'b0, occ} + {2'b00, in_flight}) < 3'd2)
                       && !(f_almost_empty_flag && in_flight);
                if (f_empty_flag && !in_flight) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Outputs are quiet while reset is applied.
        if (reset) begin
            r_en        = 1'b0;
            timeout_evt = 1'b0;
        end
    end

    always_ff @(posedge r_clk) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            in_flight <= 1'b0;   // drops a read issued just before reset
            occ       <= 2'd0;
            buf0      <= '0;
            buf1      <= '0;
            rd_count  <= '0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            in_flight <= r_en;
            if (pop) rd_count <= rd_count + CNT_W'(1);
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) buf0 <= fifo_d_out;
                    else             buf1 <= fifo_d_out;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // Head leaves; the new word lands behind whatever remains.
                    if (occ == 2'd1) begin
                        buf0 <= fifo_d_out;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= fifo_d_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
